// File: rtl/reg_write_checker_pkg.sv
// Shared definitions for the register-write checker: default parameters,
// FSM state encodings and a width helper.
package reg_write_checker_pkg;

  localparam int RWC_DATA_W    = 32;
  localparam int RWC_ADDR_W    = 5;
  localparam int RWC_DEPTH     = 16;
  localparam int RWC_TIMEOUT   = 1024;
  localparam int RWC_ERR_W     = 8;
  localparam int RWC_IGNORE_R0 = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } rwc_state_t;

  // Index width for a given golden depth; never collapses to zero bits.
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/reg_chk_golden_ram.sv
// Golden {addr, data} storage: one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
module reg_chk_golden_ram
  import reg_write_checker_pkg::*;
#(
  parameter int WIDTH = RWC_ADDR_W + RWC_DATA_W,
  parameter int DEPTH = RWC_DEPTH
) (
  input  logic                          clk,
  input  logic                          we,
  input  logic [idx_width(DEPTH)-1:0]   waddr,
  input  logic [WIDTH-1:0]              wdata,
  input  logic [idx_width(DEPTH)-1:0]   raddr,
  output logic [WIDTH-1:0]              rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/reg_write_checker.sv
// Compares a core's register-file write trace against a preloaded golden
// list, reporting mismatches, timeout and writes arriving after completion.
//
// state | meaning
// IDLE  | after reset, waiting for start
// RUN   | comparing qualifying trace writes against golden[idx]
// DONE  | result held; qualifying writes flag extra; start rearms
module reg_write_checker
  import reg_write_checker_pkg::*;
#(
  parameter int DATA_W    = RWC_DATA_W,
  parameter int ADDR_W    = RWC_ADDR_W,
  parameter int DEPTH     = RWC_DEPTH,
  parameter int TIMEOUT   = RWC_TIMEOUT,
  parameter int ERR_W     = RWC_ERR_W,
  parameter int IGNORE_R0 = RWC_IGNORE_R0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cfg_we,
  input  logic [idx_width(DEPTH)-1:0]   cfg_idx,
  input  logic [ADDR_W+DATA_W-1:0]      cfg_data,
  input  logic [idx_width(DEPTH):0]     cfg_count,
  input  logic                          start,
  input  logic                          trace_we,
  input  logic [ADDR_W-1:0]             trace_addr,
  input  logic [DATA_W-1:0]             trace_data,
  output logic                          busy,
  output logic                          done,
  output logic                          pass,
  output logic [ERR_W-1:0]              err_count,
  output logic                          timeout,
  output logic                          extra,
  output logic [idx_width(DEPTH)-1:0]   first_err_idx,
  output logic [ADDR_W+DATA_W-1:0]      first_err_got
);

  localparam int IDX_W = idx_width(DEPTH);
  localparam int ENT_W = ADDR_W + DATA_W;
  localparam int TMR_W = $clog2(TIMEOUT) + 1;

  localparam logic [IDX_W:0]   CNT_MAX  = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W:0]   CNT_ONE  = (IDX_W+1)'(1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [ERR_W-1:0] ERR_ONE  = ERR_W'(1);

  rwc_state_t state, state_nxt;

  logic [IDX_W-1:0] idx;
  logic [IDX_W:0]   count;
  logic [TMR_W-1:0] timer;
  logic [ENT_W-1:0] gold_rd;
  logic [ENT_W-1:0] trace_ent;
  logic [IDX_W:0]   cnt_clamp;

  logic addr_ok;
  logic evt;
  logic run_evt;
  logic mismatch;
  logic is_last;
  logic complete;
  logic tmo_hit;
  logic start_acc;
  logic gold_we;

  assign addr_ok   = (IGNORE_R0 == 0) || (trace_addr != '0);
  assign evt       = trace_we && addr_ok;
  assign trace_ent = {trace_addr, trace_data};
  assign cnt_clamp = (cfg_count > CNT_MAX) ? CNT_MAX : cfg_count;

  assign run_evt   = (state == ST_RUN) && evt;
  assign mismatch  = run_evt && (trace_ent != gold_rd);
  assign is_last   = ({1'b0, idx} == (count - CNT_ONE));
  assign complete  = run_evt && is_last;
  assign tmo_hit   = (state == ST_RUN) && (timer == TMR_LAST) && !complete;
  assign start_acc = start && (state != ST_RUN);
  assign gold_we   = cfg_we && (state != ST_RUN);

  reg_chk_golden_ram #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_golden (
    .clk   (clk),
    .we    (gold_we),
    .waddr (cfg_idx),
    .wdata (cfg_data),
    .raddr (idx),
    .rdata (gold_rd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_nxt = (cnt_clamp == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        // Completion takes priority over a timeout landing on the same cycle.
        if (complete || tmo_hit) begin
          state_nxt = ST_DONE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx           <= '0;
      count         <= '0;
      timer         <= '0;
      err_count     <= '0;
      timeout       <= 1'b0;
      extra         <= 1'b0;
      first_err_idx <= '0;
      first_err_got <= '0;
    end else if (start_acc) begin
      idx           <= '0;
      count         <= cnt_clamp;
      timer         <= '0;
      err_count     <= '0;
      timeout       <= 1'b0;
      extra         <= 1'b0;
      first_err_idx <= '0;
      first_err_got <= '0;
    end else if (state == ST_RUN) begin
      timer <= timer + TMR_ONE;
      if (run_evt) begin
        idx <= idx + IDX_ONE;
      end
      if (mismatch) begin
        if (err_count == '0) begin
          first_err_idx <= idx;
          first_err_got <= trace_ent;
        end
        if (err_count != '1) begin
          err_count <= err_count + ERR_ONE;
        end
      end
      if (tmo_hit) begin
        timeout <= 1'b1;
      end
    end else if ((state == ST_DONE) && evt) begin
      extra <= 1'b1;
    end
  end

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);
  assign pass = done && (err_count == '0) && !timeout && !extra;

endmodule

// File: tb/tb_reg_write_checker.sv
// Self-checking bench: directed scenarios plus randomized runs, each checked
// against a trace-level reference model of the checker's rules.
module tb_reg_write_checker;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 16;
  localparam int IW    = 4;
  localparam int GW    = AW + DW;
  localparam int TMO   = 16;
  localparam int EW    = 3;
  localparam int ERR_MAX = (1 << EW) - 1;

  logic clk = 1'b0;
  logic rst, cfg_we, start, trace_we;
  logic [IW-1:0] cfg_idx;
  logic [GW-1:0] cfg_data;
  logic [IW:0]   cfg_count;
  logic [AW-1:0] trace_addr;
  logic [DW-1:0] trace_data;

  logic busy, done, pass, timeout, extra;
  logic [EW-1:0] err_count;
  logic [IW-1:0] first_err_idx;
  logic [GW-1:0] first_err_got;

  logic r0_busy, r0_done, r0_pass, r0_timeout, r0_extra;
  logic [7:0]    r0_err;
  logic [IW-1:0] r0_fidx;
  logic [GW-1:0] r0_fgot;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          cwe;
    logic [IW-1:0] cidx;
    logic [GW-1:0] cval;
    logic          st;
  } step_t;

  step_t tr[$];
  logic [GW-1:0] gold [DEPTH];

  always #5 clk = ~clk;

  reg_write_checker #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .TIMEOUT(TMO), .ERR_W(EW), .IGNORE_R0(1)
  ) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_data(cfg_data),
    .cfg_count(cfg_count), .start(start), .trace_we(trace_we), .trace_addr(trace_addr),
    .trace_data(trace_data), .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .timeout(timeout), .extra(extra), .first_err_idx(first_err_idx), .first_err_got(first_err_got)
  );

  reg_write_checker #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .TIMEOUT(TMO), .ERR_W(8), .IGNORE_R0(0)
  ) dut_r0 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_data(cfg_data),
    .cfg_count(cfg_count), .start(start), .trace_we(trace_we), .trace_addr(trace_addr),
    .trace_data(trace_data), .busy(r0_busy), .done(r0_done), .pass(r0_pass), .err_count(r0_err),
    .timeout(r0_timeout), .extra(r0_extra), .first_err_idx(r0_fidx), .first_err_got(r0_fgot)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    cfg_we = 1'b0; cfg_idx = '0; cfg_data = '0; start = 1'b0;
    trace_we = 1'b0; trace_addr = '0; trace_data = '0;
  endtask

  task automatic load_gold(input int i, input logic [GW-1:0] v);
    cfg_we = 1'b1; cfg_idx = IW'(i); cfg_data = v;
    tick();
    cfg_we = 1'b0;
    gold[i] = v;
  endtask

  function automatic logic [GW-1:0] ent(input int a, input logic [DW-1:0] d);
    return {AW'(a), d};
  endfunction

  task automatic add(input logic we, input int a, input logic [DW-1:0] d);
    step_t s;
    s.we = we; s.addr = AW'(a); s.data = d;
    s.cwe = 1'b0; s.cidx = '0; s.cval = '0; s.st = 1'b0;
    tr.push_back(s);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_err"}, err_count, 0);
    chk({tag, "_timeout"}, timeout, 0);
    chk({tag, "_extra"}, extra, 0);
    chk({tag, "_fidx"}, first_err_idx, 0);
    chk({tag, "_fgot"}, first_err_got, 0);
  endtask

  // Run the queued trace after a start with count cnt. The model walks the
  // trace: the k-th qualifying write is compared with gold[k]; the run ends
  // on the cnt-th write or after TMO cycles, whichever comes first.
  task automatic run_check(input int cnt, input string tag);
    int ccl, dc, k, errs, fidx, n;
    logic [GW-1:0] fgot;
    bit tmo, ext, q;
    ccl = (cnt > DEPTH) ? DEPTH : cnt;
    while (tr.size() < TMO + 1) add(1'b0, 0, '0);
    n = tr.size();
    dc = (ccl == 0) ? 0 : -1;
    k = 0; errs = 0; fidx = 0; fgot = '0; tmo = 0; ext = 0;
    for (int c = 1; c <= n; c++) begin
      q = tr[c-1].we && (tr[c-1].addr != '0);
      if (dc < 0) begin
        if (q) begin
          if ({tr[c-1].addr, tr[c-1].data} != gold[k]) begin
            if (errs == 0) begin
              fidx = k;
              fgot = {tr[c-1].addr, tr[c-1].data};
            end
            if (errs < ERR_MAX) errs++;
          end
          k++;
          if (k == ccl) dc = c;
        end
        if (dc < 0 && c == TMO) begin
          dc = c;
          tmo = 1;
        end
      end else begin
        if (q) ext = 1;
        if (tr[c-1].cwe) gold[tr[c-1].cidx] = tr[c-1].cval;
      end
    end

    start = 1'b1; cfg_count = (IW+1)'(cnt);
    tick();
    start = 1'b0;
    for (int c = 1; c <= n; c++) begin
      chk({tag, "_busy"}, busy, (c - 1 < dc));
      chk({tag, "_done"}, done, (c - 1 >= dc));
      trace_we = tr[c-1].we; trace_addr = tr[c-1].addr; trace_data = tr[c-1].data;
      cfg_we = tr[c-1].cwe; cfg_idx = tr[c-1].cidx; cfg_data = tr[c-1].cval;
      start = tr[c-1].st;
      if (tr[c-1].st) cfg_count = 5'd7;
      tick();
    end
    drive_idle();
    chk({tag, "_end_busy"}, busy, 0);
    chk({tag, "_end_done"}, done, 1);
    chk({tag, "_err"}, err_count, errs);
    chk({tag, "_fidx"}, first_err_idx, fidx);
    chk({tag, "_fgot"}, first_err_got, fgot);
    chk({tag, "_timeout"}, timeout, tmo);
    chk({tag, "_extra"}, extra, ext);
    chk({tag, "_pass"}, pass, (errs == 0) && !tmo && !ext);
    tr.delete();
  endtask

  initial begin
    step_t s;
    int cnt, len, kgen;
    drive_idle();
    cfg_count = '0;
    rst = 1'b1;
    tick(); tick();
    check_all_zero("reset");
    rst = 1'b0;

    // Basic pass, then a data mismatch on the second write.
    load_gold(0, ent(31, 32'h3));
    load_gold(1, ent(30, 32'h7));
    add(1, 31, 32'h3); add(1, 30, 32'h7);
    run_check(2, "pass2");
    add(1, 31, 32'h3); add(1, 30, 32'h8);
    run_check(2, "mism");

    // Writes to r0: ignored here, compared by the IGNORE_R0=0 instance.
    rst = 1'b1; tick(); rst = 1'b0;
    load_gold(0, ent(31, 32'h3));
    load_gold(1, ent(30, 32'h7));
    add(1, 0, 32'hdead); add(1, 31, 32'h3); add(1, 30, 32'h7);
    run_check(2, "r0_ign");
    chk("r0_cmp_err_nonzero", (r0_err != 0), 1);

    // Timeout with one write missing; completion landing on the last cycle.
    add(1, 31, 32'h3);
    run_check(2, "tmo");
    add(0, 0, 0); add(0, 0, 0); add(1, 31, 32'h3);
    for (int i = 4; i < TMO; i++) add(1'b0, 0, '0);
    add(1, 30, 32'h7);
    run_check(2, "tmo_edge");

    // Extra write after completion, then a fresh start clears it.
    add(1, 31, 32'h3); add(1, 30, 32'h7); add(0, 0, 0); add(1, 5, 32'h1);
    run_check(2, "extra");
    add(1, 31, 32'h3); add(1, 30, 32'h7);
    run_check(2, "extra_clr");

    // Start and cfg writes during RUN are ignored; a cfg write in DONE lands.
    add(1, 31, 32'h3);
    tr[0].st = 1'b1; tr[0].cwe = 1'b1; tr[0].cidx = 4'd1; tr[0].cval = ent(30, 32'h99);
    add(1, 30, 32'h7);
    add(0, 0, 0);
    tr[2].cwe = 1'b1; tr[2].cidx = 4'd1; tr[2].cval = ent(30, 32'h99);
    run_check(2, "run_ign");
    add(1, 31, 32'h3); add(1, 30, 32'h99);
    run_check(2, "done_cfg");

    run_check(0, "cnt0");

    // Reset in the middle of a run discards the partial result.
    load_gold(1, ent(30, 32'h7));
    start = 1'b1; cfg_count = 5'd2;
    tick();
    start = 1'b0;
    trace_we = 1'b1; trace_addr = 5'd31; trace_data = 32'h4;
    tick();
    drive_idle();
    chk("midrst_pre_err", err_count, 1);
    chk("midrst_pre_busy", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_all_zero("midrst");
    add(1, 31, 32'h3); add(1, 30, 32'h7);
    run_check(2, "post_rst");

    // Randomized golden contents and traces.
    for (int i = 0; i < DEPTH; i++)
      load_gold(i, ent($urandom_range(1, 31), $urandom));

    // Every write wrong: error count saturates, first error stays at idx 0.
    for (int i = 0; i < 10; i++) add(1, gold[i][GW-1:DW], gold[i][DW-1:0] ^ 32'h1);
    run_check(10, "sat");

    for (int it = 0; it < 40; it++) begin
      cnt = $urandom_range(0, DEPTH + 2);
      len = $urandom_range(0, 22);
      kgen = 0;
      for (int j = 0; j < len; j++) begin
        s.we = ($urandom_range(0, 9) < 7);
        s.addr = AW'($urandom_range(1, 31));
        s.data = $urandom;
        s.cwe = ($urandom_range(0, 19) == 0);
        s.cidx = IW'($urandom_range(0, DEPTH - 1));
        s.cval = ent($urandom_range(1, 31), $urandom);
        s.st = 1'b0;
        if (s.we) begin
          case ($urandom_range(0, 9))
            0, 1: s.addr = '0;
            2, 3: ;
            default: begin
              if (kgen < DEPTH) {s.addr, s.data} = gold[kgen];
              kgen++;
            end
          endcase
        end
        tr.push_back(s);
      end
      run_check(cnt, $sformatf("rnd%0d", it));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
